// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: alu_op values, funct fields,
// 4-bit ALU control codes and the sequencer FSM states.
package alu_ctrl_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    localparam logic [3:0] CODE_AND     = 4'b0000;
    localparam logic [3:0] CODE_OR      = 4'b0001;
    localparam logic [3:0] CODE_ADD     = 4'b0010;
    localparam logic [3:0] CODE_SUB     = 4'b0110;
    localparam logic [3:0] CODE_SLT     = 4'b0111;
    localparam logic [3:0] CODE_NOR     = 4'b1100;
    localparam logic [3:0] CODE_MULT    = 4'b1000;
    localparam logic [3:0] CODE_MULTU   = 4'b1001;
    localparam logic [3:0] CODE_DIV     = 4'b1010;
    localparam logic [3:0] CODE_DIVU    = 4'b1011;
    localparam logic [3:0] CODE_ILLEGAL = 4'b1111;

    // Latency selector for multi-cycle ops.
    localparam logic LAT_MUL = 1'b0;
    localparam logic LAT_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_MULTI = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational alu_op/funct decoder. Div/divu decode only when ALU_CTRL_DIV_EN
// is defined; otherwise they fall through to illegal.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] func_op,
    output logic [3:0] code,
    output logic       is_multi,
    output logic       latency_sel,
    output logic       illegal
);

    always_comb begin
        code        = CODE_ILLEGAL;
        is_multi    = 1'b0;
        latency_sel = LAT_MUL;
        illegal     = 1'b1;
        case (alu_op)
            ALUOP_ADD: begin
                code    = CODE_ADD;
                illegal = 1'b0;
            end
            ALUOP_SUB: begin
                code    = CODE_SUB;
                illegal = 1'b0;
            end
            ALUOP_RTYPE: begin
                // Exact 6-bit match only; anything else stays illegal.
                case (func_op)
                    FUNCT_ADD: begin code = CODE_ADD; illegal = 1'b0; end
                    FUNCT_SUB: begin code = CODE_SUB; illegal = 1'b0; end
                    FUNCT_AND: begin code = CODE_AND; illegal = 1'b0; end
                    FUNCT_OR:  begin code = CODE_OR;  illegal = 1'b0; end
                    FUNCT_NOR: begin code = CODE_NOR; illegal = 1'b0; end
                    FUNCT_SLT: begin code = CODE_SLT; illegal = 1'b0; end
                    FUNCT_MULT: begin
                        code     = CODE_MULT;
                        illegal  = 1'b0;
                        is_multi = 1'b1;
                    end
                    FUNCT_MULTU: begin
                        code     = CODE_MULTU;
                        illegal  = 1'b0;
                        is_multi = 1'b1;
                    end
`ifdef ALU_CTRL_DIV_EN
                    FUNCT_DIV: begin
                        code        = CODE_DIV;
                        illegal     = 1'b0;
                        is_multi    = 1'b1;
                        latency_sel = LAT_DIV;
                    end
                    FUNCT_DIVU: begin
                        code        = CODE_DIVU;
                        illegal     = 1'b0;
                        is_multi    = 1'b1;
                        latency_sel = LAT_DIV;
                    end
`endif
                    default: ;
                endcase
            end
            ALUOP_RSVD: ;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Handshaked ALU control sequencer: decodes ops, registers one result and stretches
// mult (and, with ALU_CTRL_DIV_EN defined, div) over their multi-cycle latency.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        func_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_control_sig,
    output logic              illegal,
    output logic              hilo_we,
    output logic              busy
);

`ifdef ALU_CTRL_DIV_EN
    localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int DIV_LAT    = DIV_CYCLES;
`else
    // Div never decodes as multi-cycle here, so its load value is never selected.
    localparam int MAX_CYCLES = MUL_CYCLES;
    localparam int DIV_LAT    = MUL_CYCLES;
`endif
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (CTRL_W < 4 || MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_param_check
        $error("alu_ctrl_seq: CTRL_W must be >= 4 and cycle counts >= 1");
    end

    logic [3:0] dec_code_p0;
    logic       dec_multi_p0;
    logic       dec_lat_p0;
    logic       dec_illegal_p0;

    alu_ctrl_decode u_decode (
        .alu_op      (alu_op),
        .func_op     (func_op),
        .code        (dec_code_p0),
        .is_multi    (dec_multi_p0),
        .latency_sel (dec_lat_p0),
        .illegal     (dec_illegal_p0)
    );

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              vld_p1, vld_d;
    logic [CTRL_W-1:0] code_p1, code_d;
    logic              illegal_p1, illegal_d;
    logic              multi_p1, multi_d;
    logic              accept;

    assign in_ready = rst_n & (state_q == ST_IDLE) & (~vld_p1 | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vld_d     = vld_p1;
        code_d    = code_p1;
        illegal_d = illegal_p1;
        multi_d   = multi_p1;
        case (state_q)
            ST_IDLE: begin
                if (vld_p1 && out_ready) begin
                    vld_d = 1'b0;
                end
                if (accept) begin
                    code_d    = dec_illegal_p0 ? '1 : CTRL_W'(dec_code_p0);
                    illegal_d = dec_illegal_p0;
                    multi_d   = dec_multi_p0;
                    if (dec_multi_p0) begin
                        // Code is presented immediately; out_valid waits for the counter.
                        cnt_d   = (dec_lat_p0 == LAT_DIV) ? DIV_LOAD : MUL_LOAD;
                        vld_d   = 1'b0;
                        state_d = ST_MULTI;
                    end else begin
                        vld_d = 1'b1;
                    end
                end
            end
            ST_MULTI: begin
                if (cnt_q == '0) begin
                    vld_d   = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage p1: registered result and sequencer state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            vld_p1     <= 1'b0;
            code_p1    <= '0;
            illegal_p1 <= 1'b0;
            multi_p1   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vld_p1     <= vld_d;
            code_p1    <= code_d;
            illegal_p1 <= illegal_d;
            multi_p1   <= multi_d;
        end
    end

    assign out_valid       = vld_p1;
    assign alu_control_sig = code_p1;
    assign illegal         = illegal_p1;
    assign busy            = (state_q != ST_IDLE);
    assign hilo_we         = vld_p1 & out_ready & multi_p1;

endmodule
